// File: rtl/regfile_param_clear.sv
// Two-read/one-write register file with a hardwired-zero register, a sequenced clear after reset or on request, and same-cycle write-to-read bypass.
// Reads are combinational. Writes reach storage on the next edge. Writes are dropped while a clear sweep runs.
module regfile_param_clear #(
  parameter int DATA_WIDTH = 64,
  parameter int ADDR_WIDTH = 5,
  parameter bit ZERO_EN    = 1'b1,
  parameter int ZERO_REG   = 31
) (
  input  logic                  Clk,
  input  logic                  Reset_n,
  input  logic [ADDR_WIDTH-1:0] RA,
  input  logic [ADDR_WIDTH-1:0] RB,
  input  logic [ADDR_WIDTH-1:0] RW,
  input  logic [DATA_WIDTH-1:0] BusW,
  input  logic                  RegWr,
  input  logic                  ClearReq,
  output logic [DATA_WIDTH-1:0] BusA,
  output logic [DATA_WIDTH-1:0] BusB,
  output logic                  Ready
);

  localparam int                  DEPTH     = 1 << ADDR_WIDTH;
  localparam logic [ADDR_WIDTH-1:0] ZERO_ADDR = ADDR_WIDTH'(ZERO_REG);
  localparam logic [ADDR_WIDTH:0]   LAST_IDX  = (ADDR_WIDTH+1)'(DEPTH - 1);

  typedef enum logic {
    ST_CLEAR = 1'b0,
    ST_RUN   = 1'b1
  } state_t;

  state_t                state;
  state_t                state_nxt;
  logic [ADDR_WIDTH:0]   clr_idx;
  logic [ADDR_WIDTH:0]   clr_idx_nxt;
  logic                  wr_en;
  logic [ADDR_WIDTH-1:0] wr_addr;
  logic [DATA_WIDTH-1:0] wr_data;
  logic                  zero_hit_w;
  logic                  zero_hit_a;
  logic                  zero_hit_b;

  logic [DATA_WIDTH-1:0] mem [DEPTH];

  assign zero_hit_w = ZERO_EN && (RW == ZERO_ADDR);
  assign zero_hit_a = ZERO_EN && (RA == ZERO_ADDR);
  assign zero_hit_b = ZERO_EN && (RB == ZERO_ADDR);

  always_ff @(posedge Clk or negedge Reset_n) begin
    if (!Reset_n) begin
      state   <= ST_CLEAR;
      clr_idx <= '0;
    end else begin
      state   <= state_nxt;
      clr_idx <= clr_idx_nxt;
    end
  end

  // The sweep shares the single write port, so user writes are simply not issued in CLEAR.
  always_comb begin
    state_nxt   = state;
    clr_idx_nxt = clr_idx;
    wr_en       = 1'b0;
    wr_addr     = RW;
    wr_data     = BusW;
    Ready       = 1'b0;
    case (state)
      ST_CLEAR: begin
        wr_en       = 1'b1;
        wr_addr     = clr_idx[ADDR_WIDTH-1:0];
        wr_data     = '0;
        clr_idx_nxt = clr_idx + 1'b1;
        if (clr_idx == LAST_IDX) begin
          state_nxt = ST_RUN;
        end
      end
      ST_RUN: begin
        Ready = 1'b1;
        if (ClearReq) begin
          state_nxt   = ST_CLEAR;
          clr_idx_nxt = '0;
        end else if (RegWr && !zero_hit_w) begin
          wr_en = 1'b1;
        end
      end
      default: begin
        state_nxt   = ST_CLEAR;
        clr_idx_nxt = '0;
      end
    endcase
  end

  // Storage carries no reset; the sweep is what zeroes it.
  always_ff @(posedge Clk) begin
    if (wr_en) begin
      mem[wr_addr] <= wr_data;
    end
  end

  // Zero register beats bypass, so a write to it never leaks onto a read port.
  always_comb begin
    BusA = '0;
    BusB = '0;
    if (state == ST_RUN) begin
      if (zero_hit_a) begin
        BusA = '0;
      end else if (RegWr && (RA == RW)) begin
        BusA = BusW;
      end else begin
        BusA = mem[RA];
      end
      if (zero_hit_b) begin
        BusB = '0;
      end else if (RegWr && (RB == RW)) begin
        BusB = BusW;
      end else begin
        BusB = mem[RB];
      end
    end
  end

endmodule
